nn_mem_port_arbiter: RTL and testbench

//  Shares one port of a dpram32x32_cb (kernel or weight memory) between N_REQ requesters:
//   - the learn-path loader (writes);
//   - the classify-path conv/FC engines (reads).

---
 rtl/nn_mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_nn_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mem_port_arbiter.sv
// nn_mem_port_arbiter
//   Shares one port of a dpram32x32_cb between N_REQ requesters with
//   round-robin arbitration and bounded bursts. Drives the active-low RAM
//   controls in the grant cycle and returns read data RD_LAT cycles later
//   with a per-requester valid strobe.
//
//   Handshake: a requester holds req_i with its we_i/addr_i/wdata_i stable;
//   the access is performed in the cycle where req_i[k] & gnt_o[k]. A read
//   returns as a one-cycle rvalid_o[k] pulse with rdata_o RD_LAT cycles later.
//
//   Optional build macro ARB_FIXED_PRIO_EN: fixed priority (requester 0
//   highest) with a one-cycle forced release when an owner exhausts its burst.
module nn_mem_port_arbiter #(
    parameter int N_REQ     = 2,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         we_i,
    input  logic [N_REQ*ADDR_W-1:0]  addr_i,
    input  logic [N_REQ*DATA_W-1:0]  wdata_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [N_REQ-1:0]         rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_csb,
    output logic                     mem_web,
    output logic                     mem_oeb,
    output logic [DATA_W-1:0]        mem_i,
    input  logic [DATA_W-1:0]        mem_o
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    logic              owner_vld;
    logic [ID_W-1:0]   owner;
    logic [CNT_W-1:0]  cnt;
    logic [N_REQ-1:0]  owner_oh;
    logic              at_limit;
    logic [ID_W-1:0]   scan_base;
    logic [N_REQ-1:0]  masked_req;
    logic [N_REQ-1:0]  req_rot;
    logic              win_vld;
    logic [ID_W-1:0]   win_off;
    logic [ID_W:0]     win_sum;
    logic [ID_W-1:0]   win;
    logic              grant_en;
    logic              gnt_we;

    logic              rd_vld [RD_LAT];
    logic [ID_W-1:0]   rd_id  [RD_LAT];

`ifndef ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   owner_inc;
    logic              release_now;
`endif

    assign at_limit = owner_vld && (cnt >= CNT_W'(BURST_LEN));

`ifndef ARB_FIXED_PRIO_EN
    // Release happens when the owner drops its request or exhausts its burst;
    // the scan then starts just past the old owner so it is considered last.
    assign owner_inc   = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign release_now = owner_vld && (!req_i[owner] || at_limit);
    assign scan_base   = release_now ? owner_inc : ptr;
`else
    assign scan_base   = '0;
`endif

    // One-hot view of the current owner
    always_comb begin
        owner_oh = '0;
        if (owner_vld) owner_oh = N_REQ'(1) << owner;
    end

    // Winner selection: an owner at its burst limit is masked out whenever
    // anyone else is waiting; the rotated scan then picks the first request.
    always_comb begin
        masked_req = req_i;
        if (at_limit && |(req_i & ~owner_oh)) masked_req = req_i & ~owner_oh;
        req_rot = N_REQ'({masked_req, masked_req} >> scan_base);
        win_vld = 1'b0;
        win_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_vld = 1'b1;
                win_off = ID_W'(k);
            end
        end
        win_sum = {1'b0, scan_base} + (ID_W + 1)'(win_off);
        if (win_sum >= (ID_W + 1)'(N_REQ)) win_sum = win_sum - (ID_W + 1)'(N_REQ);
        win = win_sum[ID_W-1:0];
    end

    assign grant_en = win_vld && !rst;

    // One-hot grant, suppressed while reset is asserted
    always_comb begin
        gnt_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_en && (win == ID_W'(k))) gnt_o[k] = 1'b1;
        end
    end

    // RAM drive for the granted requester; idle values otherwise
    always_comb begin
        mem_csb = 1'b1;
        mem_web = 1'b1;
        mem_a   = '0;
        mem_i   = '0;
        gnt_we  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_o[k]) begin
                mem_csb = 1'b0;
                mem_web = ~we_i[k];
                mem_a   = addr_i[k*ADDR_W +: ADDR_W];
                mem_i   = wdata_i[k*DATA_W +: DATA_W];
                gnt_we  = we_i[k];
            end
        end
    end

    // Arbiter state: owner, burst counter and rotation pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_vld <= 1'b0;
            owner     <= '0;
            cnt       <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr       <= '0;
`endif
        end else if (win_vld) begin
            if (owner_vld && (win == owner) && !at_limit) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                owner_vld <= 1'b1;
                owner     <= win;
                cnt       <= CNT_W'(1);
            end
`ifndef ARB_FIXED_PRIO_EN
            if (release_now) ptr <= owner_inc;
`endif
        end else begin
            owner_vld <= 1'b0;
            owner     <= '0;
            cnt       <= '0;
        end
    end

    // Read-return pipeline: carries (valid, id) for RD_LAT cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                rd_vld[s] <= 1'b0;
                rd_id[s]  <= '0;
            end
        end else begin
            rd_vld[0] <= grant_en && !gnt_we;
            rd_id[0]  <= win;
            for (int s = 1; s < RD_LAT; s++) begin
                rd_vld[s] <= rd_vld[s-1];
                rd_id[s]  <= rd_id[s-1];
            end
        end
    end

    // Output stage: strobe the owning requester and enable RAM output
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        mem_oeb  = 1'b1;
        if (rd_vld[RD_LAT-1]) begin
            rvalid_o = N_REQ'(1) << rd_id[RD_LAT-1];
            rdata_o  = mem_o;
            mem_oeb  = 1'b0;
        end
    end

endmodule

// File: tb/tb_nn_mem_port_arbiter.sv
// Bench for nn_mem_port_arbiter: synchronous RAM model, read-data scoreboard
// and directed scenarios for reset, single read, bursts, write/read, release.
// Build with +define+ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_nn_mem_port_arbiter;

  localparam int N_REQ     = 2;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;
  localparam int RD_LAT    = 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        req_i = '0;
  logic [N_REQ-1:0]        we_i = '0;
  logic [N_REQ*ADDR_W-1:0] addr_i = '0;
  logic [N_REQ*DATA_W-1:0] wdata_i = '0;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        rvalid_o;
  logic [DATA_W-1:0]       rdata_o;
  logic [ADDR_W-1:0]       mem_a;
  logic                    mem_csb;
  logic                    mem_web;
  logic                    mem_oeb;
  logic [DATA_W-1:0]       mem_i;
  logic [DATA_W-1:0]       mem_o;

  logic [DATA_W-1:0]       ram [32];
  logic [DATA_W-1:0]       model_mem [32];
  logic [N_REQ+DATA_W-1:0] exp_q [$];
  logic [N_REQ+DATA_W-1:0] exp_v;
  logic [N_REQ-1:0]        oh;

  int pass_cnt  = 0;
  int total_cnt = 0;

  nn_mem_port_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BURST_LEN(BURST_LEN), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_a(mem_a), .mem_csb(mem_csb), .mem_web(mem_web), .mem_oeb(mem_oeb),
    .mem_i(mem_i), .mem_o(mem_o)
  );

  // clock
  always #5 clk = ~clk;

  // synchronous RAM, one cycle read latency
  always @(posedge clk) begin
    if (!mem_csb) begin
      if (!mem_web) ram[mem_a] <= mem_i;
      else          mem_o <= ram[mem_a];
    end
  end

  // scoreboard: pop on rvalid, push on granted reads, track writes
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rvalid_o != '0) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_rvalid got rvalid=%b rdata=%h want none", rvalid_o, rdata_o);
        end else begin
          exp_v = exp_q.pop_front();
          if ({rvalid_o, rdata_o} !== exp_v)
            $display("FAIL sb_read got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                     rvalid_o, rdata_o, exp_v[N_REQ+DATA_W-1:DATA_W], exp_v[DATA_W-1:0]);
          else pass_cnt++;
        end
      end
      for (int k = 0; k < N_REQ; k++) begin
        if (gnt_o[k] && req_i[k]) begin
          if (we_i[k]) begin
            model_mem[addr_i[k*ADDR_W +: ADDR_W]] = wdata_i[k*DATA_W +: DATA_W];
          end else begin
            oh = '0;
            oh[k] = 1'b1;
            exp_q.push_back({oh, model_mem[addr_i[k*ADDR_W +: ADDR_W]]});
          end
        end
      end
    end
  end

  // driver tasks
  task automatic set_req(input int k, input logic r, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_i[k] = r;
    we_i[k]  = w;
    addr_i[k*ADDR_W +: ADDR_W]  = a;
    wdata_i[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle();
    req_i = '0;
    we_i  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (RD_LAT + 2) step();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    total_cnt++;
    if ({gnt_o, rvalid_o, rdata_o, mem_a, mem_csb, mem_web, mem_oeb, mem_i} !==
        {N_REQ'(0), N_REQ'(0), DATA_W'(0), ADDR_W'(0), 3'b111, DATA_W'(0)})
      $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%h a=%0d csb=%b web=%b oeb=%b i=%h want all idle",
               gnt_o, rvalid_o, rdata_o, mem_a, mem_csb, mem_web, mem_oeb, mem_i);
    else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    // start a read, then reset while it is in flight
    set_req(0, 1'b1, 1'b0, 5'd3, '0);
    step();
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({gnt_o, rvalid_o, rdata_o, mem_a, mem_csb, mem_web, mem_oeb, mem_i} !==
        {N_REQ'(0), N_REQ'(0), DATA_W'(0), ADDR_W'(0), 3'b111, DATA_W'(0)})
      $display("FAIL reset_mid_read got gnt=%b rvalid=%b rdata=%h csb=%b oeb=%b want idle",
               gnt_o, rvalid_o, rdata_o, mem_csb, mem_oeb);
    else pass_cnt++;
    step();
    idle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total_cnt++;
      if (rvalid_o !== '0) $display("FAIL reset_no_rvalid cycle %0d got %b want 00", c, rvalid_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_preload();
    for (int a = 0; a < 32; a++) begin
      set_req(0, 1'b1, 1'b1, ADDR_W'(a), (a == 5) ? 32'hDEADBEEF : DATA_W'($urandom));
      step();
    end
    drain();
  endtask

  task automatic test_burst();
    logic [N_REQ-1:0] seq [10];
`ifdef ARB_FIXED_PRIO_EN
    seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`else
    seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
`endif
    set_req(0, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 31)), '0);
    set_req(1, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 31)), '0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total_cnt++;
      if (gnt_o !== seq[c]) $display("FAIL burst_grant cycle %0d got %b want %b", c, gnt_o, seq[c]);
      else pass_cnt++;
      step();
      set_req(0, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 31)), '0);
      set_req(1, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 31)), '0);
    end
    drain();
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 1'b0, 5'd5, '0);
    @(negedge clk);
    total_cnt++;
    if ({gnt_o, mem_csb, mem_web, mem_a} !== {2'b01, 1'b0, 1'b1, 5'd5})
      $display("FAIL single_read_grant got gnt=%b csb=%b web=%b a=%0d want 01 0 1 5",
               gnt_o, mem_csb, mem_web, mem_a);
    else pass_cnt++;
    step();
    idle();
    @(negedge clk);
    total_cnt++;
    if ({rvalid_o, rdata_o, mem_oeb} !== {2'b01, 32'hDEADBEEF, 1'b0})
      $display("FAIL single_read_data got rvalid=%b rdata=%h oeb=%b want 01 deadbeef 0",
               rvalid_o, rdata_o, mem_oeb);
    else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++;
    if (mem_oeb !== 1'b1) $display("FAIL single_read_oeb_idle got %b want 1", mem_oeb);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_write_read();
    set_req(1, 1'b1, 1'b1, 5'd31, 32'h12345678);
    @(negedge clk);
    total_cnt++;
    if ({gnt_o, mem_csb, mem_web, mem_a, mem_i} !== {2'b10, 1'b0, 1'b0, 5'd31, 32'h12345678})
      $display("FAIL write_cycle got gnt=%b csb=%b web=%b a=%0d i=%h want 10 0 0 31 12345678",
               gnt_o, mem_csb, mem_web, mem_a, mem_i);
    else pass_cnt++;
    step();
    set_req(1, 1'b1, 1'b0, 5'd31, '0);
    @(negedge clk);
    total_cnt++;
    if ({gnt_o, mem_web, rvalid_o} !== {2'b10, 1'b1, 2'b00})
      $display("FAIL read_after_write_cycle got gnt=%b web=%b rvalid=%b want 10 1 00",
               gnt_o, mem_web, rvalid_o);
    else pass_cnt++;
    step();
    idle();
    @(negedge clk);
    total_cnt++;
    if ({rvalid_o, rdata_o} !== {2'b10, 32'h12345678})
      $display("FAIL read_after_write_data got rvalid=%b rdata=%h want 10 12345678", rvalid_o, rdata_o);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_release();
    set_req(0, 1'b1, 1'b0, 5'd1, '0);
    @(negedge clk);
    total_cnt++;
    if (gnt_o !== 2'b01) $display("FAIL release_g1 got %b want 01", gnt_o);
    else pass_cnt++;
    step();
    set_req(1, 1'b1, 1'b0, 5'd2, '0);
    @(negedge clk);
    total_cnt++;
    if (gnt_o !== 2'b01) $display("FAIL release_g2 got %b want 01", gnt_o);
    else pass_cnt++;
    step();
    set_req(0, 1'b0, 1'b0, 5'd1, '0);
    @(negedge clk);
    total_cnt++;
    if (gnt_o !== 2'b10) $display("FAIL release_handover got %b want 10", gnt_o);
    else pass_cnt++;
    step();
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < N_REQ; k++)
        set_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom));
      step();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_preload();
    do_reset();
    test_burst();
    test_single_read();
    test_write_read();
    test_release();
    test_random();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d pending reads want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
